lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Core-side load/store unit: initiator for the data-memory port (req/we/be/addr/wd -> rd/ready).
//  Turns a core load/store (funct3 size code, byte address) into a word-aligned memory request with
//  byte enables and lane-replicated write data. Extracts and sign/zero-extends load data.
//  Stalls the core until the access completes. Sits between the datapath and data_mem.
// PARAMETERS
//  ADDR_WIDTH  32  width of core_addr_i / mem_addr_o
// PORTS
//  clk_i           in   1   clock; all state updates on posedge
//  rst_i           in   1   synchronous, active-high reset
//  core_req_i      in   1   core requests a memory access; held with other core_* inputs while stalled
//  core_we_i       in   1   1 = store, 0 = load
//  core_size_i     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  core_addr_i     in   AW  byte address
//  core_wd_i       in   32  store data (LSBs used for B/H)
//  core_rd_o       out  32  extended load data; valid in DONE, held until next load completes
//  core_stall_o    out  1   core must freeze this cycle
//  mem_req_o       out  1   memory request (registered)
//  mem_we_o        out  1   memory write enable (registered)
//  mem_be_o        out  4   byte enables (registered)
//  mem_addr_o      out  AW  address, core_addr_i with [1:0] forced to 0 (registered)
//  mem_wd_o        out  32  lane-replicated write data (registered)
//  mem_rd_i        in   32  read word, valid the cycle after acceptance
//  mem_ready_i     in   1   memory accepts request when mem_req_o & mem_ready_i
// BEHAVIOUR
//  - Reset: state IDLE; mem_req_o/mem_we_o 0, mem_be_o 0, mem_addr_o 0, mem_wd_o 0, core_rd_o 0;
//    core_stall_o forced 0 while rst_i high. Reset mid-access aborts: mem_req_o 0 after that edge.
//  - FSM IDLE -> REQ -> (RESP) -> DONE -> IDLE.
//    IDLE: core_stall_o = core_req_i. On core_req_i: register mem_* outputs, mem_req_o<=1, -> REQ.
//    REQ : core_stall_o=1; mem_* held stable. mem_ready_i=0 -> stay. mem_ready_i=1: store -> DONE,
//          load -> RESP; mem_req_o<=0 on leaving.
//    RESP: core_stall_o=1; capture extended mem_rd_i into core_rd_o; -> DONE.
//    DONE: core_stall_o=0 (core retires instruction); -> IDLE. New request accepted only from IDLE.
//  - Latency with mem_ready_i=1: load stalls 3 cycles, store 2; each ready=0 cycle in REQ adds one.
//  - Byte lanes (off = addr[1:0]): B/BU be=4'b0001<<off, wd={4{wd[7:0]}};
//    H/HU be=addr[1]?4'b1100:4'b0011, wd={2{wd[15:0]}}; W be=4'b1111, wd=wd. Loads drive same be.
//  - Load extract: B/BU byte at lane off, H/HU halfword at lane addr[1]; B/H sign-extend, BU/HU zero.
//  - Undefined size codes (011, 110, 111) behave as W.
//  - mem_rd_i sampled only in RESP; mem_ready_i ignored outside REQ.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: extra port core_misalign_o (out, 1, reset 0). H/HU with addr[0]=1
//    or W with addr[1:0]!=0 is not issued: IDLE -> DONE directly (mem_req_o stays 0), core_misalign_o=1
//    in DONE only, core_rd_o unchanged.
//  Undefined: no port; H ignores addr[0], W ignores addr[1:0] (access aligned down, issued normally).
// TESTING
//  - Reset then SW addr 0x10 wd 0xDEADBEEF, ready=1 -> one cycle mem_req_o=1, be=1111, addr=0x10, stall 2 cycles.
//  - SB addr 0x13 wd 0x000000A5 -> be=1000, mem_wd_o=0xA5A5A5A5; then LB 0x13, rd_i=0xA5000000 ->
//    core_rd_o=0xFFFFFFA5 in DONE; LBU same -> 0x000000A5.
//  - LH addr 0x12, rd_i=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LH addr 0x10 -> 0x00001234.
//  - LW with mem_ready_i low 3 cycles in REQ -> mem_* stable, stall 6 cycles total, then core_rd_o=rd_i.
//  - rst_i pulsed while in REQ -> next cycle mem_req_o=0, state IDLE, core_rd_o=0.
//  - LSU_MISALIGN_CHECK_EN: LW addr 0x11 -> mem_req_o never 1, core_misalign_o=1 one cycle, stall 1 cycle.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Core-side and data-memory-side signals of the load/store unit.
// LSU_MISALIGN_CHECK_EN adds the core_misalign_o flag.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [2:0]            core_size_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [31:0]           core_wd_i;
  logic [31:0]           core_rd_o;
  logic                  core_stall_o;
`ifdef LSU_MISALIGN_CHECK_EN
  logic                  core_misalign_o;
`endif
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wd_o;
  logic [31:0]           mem_rd_i;
  logic                  mem_ready_i;

  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
`ifdef LSU_MISALIGN_CHECK_EN
    output core_misalign_o,
`endif
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
`ifdef LSU_MISALIGN_CHECK_EN
    input  core_misalign_o,
`endif
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: core access -> word-aligned memory request, load extraction, core stall.
// Optional LSU_MISALIGN_CHECK_EN: misaligned H/W accesses are not issued and flagged instead.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  lsu_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                state_reg;
  logic                  mem_req_reg;
  logic                  mem_we_reg;
  logic [3:0]            mem_be_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]           mem_wd_reg;
  logic [31:0]           core_rd_reg;
  logic [2:0]            size_reg;
  logic [1:0]            off_reg;

  logic        is_byte;
  logic        is_half;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] rd_ext_next;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        misalign;
  logic        stall_next;
  logic [7:0]  rd_lane [4];

  assign off     = bus.core_addr_i[1:0];
  assign is_byte = (bus.core_size_i[1:0] == 2'b00);
  assign is_half = (bus.core_size_i[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_reg;
  assign misalign = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
  assign bus.core_misalign_o = misalign_reg;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_next = 4'b1111;
    wd_next = bus.core_wd_i;
    if (is_byte) begin
      be_next = 4'b0001 << off;
      wd_next = {4{bus.core_wd_i[7:0]}};
    end else if (is_half) begin
      be_next = off[1] ? 4'b1100 : 4'b0011;
      wd_next = {2{bus.core_wd_i[15:0]}};
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = bus.mem_rd_i[8*gi +: 8];
  end

  // size_reg[2] marks the unsigned variants; codes 01x/11x fall through to word
  always_comb begin
    rd_byte     = rd_lane[off_reg];
    rd_half     = off_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
    rd_ext_next = bus.mem_rd_i;
    case (size_reg[1:0])
      2'b00:   rd_ext_next = {{24{rd_byte[7] & ~size_reg[2]}}, rd_byte};
      2'b01:   rd_ext_next = {{16{rd_half[15] & ~size_reg[2]}}, rd_half};
      default: rd_ext_next = bus.mem_rd_i;
    endcase
  end

  always_comb begin
    stall_next = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        IDLE:     stall_next = bus.core_req_i;
        REQ,
        RESP:     stall_next = 1'b1;
        default:  stall_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_be_reg   <= 4'b0000;
      mem_addr_reg <= '0;
      mem_wd_reg   <= 32'h0;
      core_rd_reg  <= 32'h0;
      size_reg     <= 3'b000;
      off_reg      <= 2'b00;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.core_req_i) begin
            if (misalign) begin
              state_reg <= DONE;
`ifdef LSU_MISALIGN_CHECK_EN
              misalign_reg <= 1'b1;
`endif
            end else begin
              mem_req_reg  <= 1'b1;
              mem_we_reg   <= bus.core_we_i;
              mem_be_reg   <= be_next;
              mem_addr_reg <= {bus.core_addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_wd_reg   <= wd_next;
              size_reg     <= bus.core_size_i;
              off_reg      <= off;
              state_reg    <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready_i) begin
            mem_req_reg <= 1'b0;
            state_reg   <= mem_we_reg ? DONE : RESP;
          end
        end
        RESP: begin
          core_rd_reg <= rd_ext_next;
          state_reg   <= DONE;
        end
        default: begin
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_reg <= 1'b0;
`endif
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.core_stall_o = stall_next;
  assign bus.core_rd_o    = core_rd_reg;
  assign bus.mem_req_o    = mem_req_reg;
  assign bus.mem_we_o     = mem_we_reg;
  assign bus.mem_be_o     = mem_be_reg;
  assign bus.mem_addr_o   = mem_addr_reg;
  assign bus.mem_wd_o     = mem_wd_reg;
endmodule
